// File: rtl/reg_file_wr_ctl.sv
// Register-file write-cycle sequencer: SETUP / STROBE / HOLD around each write,
// with a single-entry pending slot and a sticky overrun flag for dropped requests.
module reg_file_wr_ctl #(
  parameter int unsigned STROBE_LEN = 2
) (
  input  logic       CK,
  input  logic       RESET_n,
  input  logic [4:0] CSDEST,
  input  logic       LCS_n,
  input  logic       WRTRF,
  input  logic       RRF_REQ,
  input  logic       CLR_OVR,
  output logic       WRF_n,
  output logic       WADDR_LE,
  output logic       DBUF_OE_n,
  output logic       BUSY,
  output logic       WDONE,
  output logic       OVERRUN,
  output logic       RD_STALL
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       ovr_q, ovr_d;
  logic       req;
  logic       ovr_set;

  always_comb begin
    req     = WRTRF | (LCS_n & (CSDEST == 5'd5));
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = SETUP;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(STROBE_LEN - 1);
        if (req) begin
          if (pend_q) ovr_set = 1'b1;
          else        pend_d  = 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 4'd1;
        if (req) begin
          if (pend_q) ovr_set = 1'b1;
          else        pend_d  = 1'b1;
        end
      end
      HOLD: begin
        // A held request starts the next write; a fresh one on this edge refills the slot.
        if (pend_q | req) begin
          state_d = SETUP;
          pend_d  = pend_q & req;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ovr_d = ovr_set | (ovr_q & ~CLR_OVR);
  end

  always_ff @(posedge CK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign WADDR_LE  = (state_q == SETUP);
  assign WRF_n     = (state_q != STROBE);
  assign DBUF_OE_n = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign WDONE     = (state_q == HOLD);
  assign OVERRUN   = ovr_q;
  assign RD_STALL  = RRF_REQ & ((state_q == STROBE) | (state_q == HOLD));

endmodule

// File: tb/tb_reg_file_wr_ctl.sv
// Directed and random stimulus for reg_file_wr_ctl against a cycle-position model.
module tb_reg_file_wr_ctl;

  localparam int unsigned L = 2;

  logic       CK;
  logic       RESET_n;
  logic [4:0] CSDEST;
  logic       LCS_n;
  logic       WRTRF;
  logic       RRF_REQ;
  logic       CLR_OVR;
  logic       WRF_n;
  logic       WADDR_LE;
  logic       DBUF_OE_n;
  logic       BUSY;
  logic       WDONE;
  logic       OVERRUN;
  logic       RD_STALL;

  int checks   = 0;
  int failures = 0;

  // Model: pos counts clocks into the current write (0 = no write in progress),
  // queued is the number of accepted-but-not-started writes.
  int pos    = 0;
  int queued = 0;
  bit ovr    = 0;
  int cyc_no = 0;

  reg_file_wr_ctl #(.STROBE_LEN(L)) dut (
    .CK(CK), .RESET_n(RESET_n), .CSDEST(CSDEST), .LCS_n(LCS_n), .WRTRF(WRTRF),
    .RRF_REQ(RRF_REQ), .CLR_OVR(CLR_OVR), .WRF_n(WRF_n), .WADDR_LE(WADDR_LE),
    .DBUF_OE_n(DBUF_OE_n), .BUSY(BUSY), .WDONE(WDONE), .OVERRUN(OVERRUN),
    .RD_STALL(RD_STALL)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic check_all();
    bit in_setup, in_strobe, in_hold;
    in_setup  = (pos == 1);
    in_strobe = (pos >= 2) && (pos <= int'(L) + 1);
    in_hold   = (pos == int'(L) + 2);
    chk("WRF_n",     WRF_n,     !in_strobe);
    chk("WADDR_LE",  WADDR_LE,  in_setup);
    chk("DBUF_OE_n", DBUF_OE_n, pos == 0);
    chk("BUSY",      BUSY,      pos != 0);
    chk("WDONE",     WDONE,     in_hold);
    chk("OVERRUN",   OVERRUN,   ovr);
    chk("RD_STALL",  RD_STALL,  RRF_REQ && (in_strobe || in_hold));
  endtask

  task automatic model_edge(input bit req, input bit clr);
    bit set_ovr;
    set_ovr = 0;
    if (pos == 0) begin
      if (req) pos = 1;
    end else if (pos < int'(L) + 2) begin
      if (req) begin
        if (queued > 0) set_ovr = 1;
        else            queued  = 1;
      end
      pos++;
    end else begin
      if (queued + int'(req) > 0) begin
        queued = queued + int'(req) - 1;
        pos    = 1;
      end else begin
        pos = 0;
      end
    end
    if (set_ovr)  ovr = 1;
    else if (clr) ovr = 0;
  endtask

  task automatic cyc(input bit w, input bit l, input logic [4:0] d, input bit rrf, input bit clr);
    bit req;
    WRTRF = w; LCS_n = l; CSDEST = d; RRF_REQ = rrf; CLR_OVR = clr;
    req = w || (l && d == 5'd5);
    @(posedge CK);
    model_edge(req, clr);
    cyc_no++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 0, 0);
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    #1;
    pos = 0; queued = 0; ovr = 0;
    check_all();
    #2;
    RESET_n = 1'b1;
  endtask

  initial begin
    RESET_n = 1'b0; WRTRF = 0; LCS_n = 0; CSDEST = '0; RRF_REQ = 0; CLR_OVR = 0;
    #1;
    check_all();
    @(negedge CK);
    RESET_n = 1'b1;

    // Single decoded write: SETUP, 2 STROBE, HOLD, then IDLE.
    cyc(0, 1, 5'd5, 0, 0);
    chk("t037_addr_le", WADDR_LE, 1'b1);
    idle(6);

    // Decode qualifiers that must not start a write.
    for (int i = 0; i < 3; i++) cyc(0, 0, 5'd5, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'd4, 0, 0);
    chk("t038_busy", BUSY, 1'b0);

    // Second request during STROBE queues behind the first.
    cyc(1, 0, 5'd0, 0, 0);
    idle(1);
    cyc(1, 0, 5'd0, 0, 0);
    idle(9);
    chk("t039_ovr", OVERRUN, 1'b0);

    // Third request while one is pending is dropped.
    cyc(1, 0, 5'd0, 0, 0);
    cyc(1, 0, 5'd0, 0, 0);
    cyc(1, 0, 5'd0, 0, 0);
    chk("t040_ovr_set", OVERRUN, 1'b1);
    idle(3);
    cyc(0, 0, 5'd0, 0, 1);
    chk("t040_ovr_clr", OVERRUN, 1'b0);
    idle(6);

    // Reset during STROBE with a pending write.
    cyc(1, 0, 5'd0, 0, 0);
    cyc(1, 0, 5'd0, 0, 0);
    do_reset();
    chk("t041_wrf_n", WRF_n, 1'b1);
    idle(8);

    // Request on the very first edge after reset release.
    do_reset();
    cyc(1, 0, 5'd0, 0, 0);
    chk("t036_accept", BUSY, 1'b1);
    idle(5);

    // Read requests overlapping a write.
    cyc(1, 0, 5'd0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 5'd0, 1, 0);
    idle(2);

    // Random traffic with sparse requests, clears and reads.
    for (int i = 0; i < 600; i++) begin
      bit w, l, rrf, clr;
      logic [4:0] d;
      w   = ($urandom_range(0, 99) < 20);
      l   = $urandom_range(0, 1) == 1;
      d   = ($urandom_range(0, 3) == 0) ? 5'd5 : 5'($urandom_range(0, 31));
      rrf = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 99) < 8);
      cyc(w, l, d, rrf, clr);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
